syn_weight_mem: RTL and testbench
=================================

Name: syn_weight_mem

Overview:
- Parametrised synaptic weight memory for one neuron: stores one signed weight per presynaptic source and answers AER spike events with that source's weight.
- Adds to the previous weight RAM:
  - an input event FIFO with valid/ready handshake;
  - an output valid/ready handshake;
  - a sequential clear state machine;
  - defined out-of-range address handling.
- Sits between the AER bus and the neuron's membrane integrator; a configuration host programs it through the write port.

Parameters:
- N_NEURONS, 16, number of presynaptic sources (memory depth); must be <= 2**ADDR_W.
- ADDR_W, 4, width of AER and synapse addresses.
- WEIGHT_W, 11, weight width, two's complement.
- FIFO_DEPTH, 4, input event FIFO depth (power of two, >= 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- we  in  1  write strobe for syn_addr/syn_weight
- syn_addr  in  ADDR_W  write address
- syn_weight  in  WEIGHT_W  write data
- clear  in  1  one-cycle pulse: start zeroing all weights
- busy  out  1  high while the clear sweep runs
- aer_valid  in  1  spike event present
- aer_addr  in  ADDR_W  source address of the spike
- aer_ready  out  1  FIFO can accept an event
- weight_valid  out  1  weight_out holds a looked-up weight
- weight_out  out  WEIGHT_W  weight of the oldest pending event
- weight_ready  in  1  integrator consumes weight_out

Behaviour:
- Reset (async assert, sync deassert by user):
  - FIFO empty; weight_valid=0; weight_out=0.
  - FSM enters CLEAR with sweep counter 0; busy=1.
  - Memory contents are undefined until the post-reset sweep completes.
- FSM states:
  - IDLE: busy=0. clear=1 -> CLEAR with counter 0.
  - CLEAR: busy=1; each cycle writes 0 to memory[counter] and increments the counter. After writing address N_NEURONS-1 -> IDLE, so busy is high for exactly N_NEURONS cycles.
  - clear asserted during CLEAR is ignored.
- Write port:
  - In IDLE, we=1 writes syn_weight to memory[syn_addr] on the edge.
  - In CLEAR, we is ignored (dropped, not queued).
  - syn_addr >= N_NEURONS: the write is ignored.
- Event input:
  - aer_ready = (FIFO count < FIFO_DEPTH); it is independent of busy, so events are queued during CLEAR.
  - An event is accepted on an edge with aer_valid & aer_ready.
  - When full, aer_ready=0; a simultaneous pop frees a slot only from the next cycle (no same-cycle push-through).
- Lookup stage: pop the FIFO head and read memory when all of the following hold:
  - FIFO not empty;
  - state == IDLE;
  - we == 0 (writes have priority; the read stalls one cycle, so a same-cycle write is always visible to the later read);
  - output free: !weight_valid | weight_ready.
- Lookup result:
  - Registered: weight_out <= memory[head], or 0 if head >= N_NEURONS; weight_valid <= 1.
  - If no pop occurs and weight_ready=1, weight_valid <= 0.
- Output hold: weight_out and weight_valid stay stable while weight_valid & !weight_ready.
- Latency:
  - Accepted on edge k into an empty FIFO with no stall -> weight_valid=1 after edge k+1.
  - Sustained throughput is 1 event/cycle.
- Ordering: weights are returned strictly in event-acceptance order; none dropped or duplicated.
- Simultaneous push and pop on a non-full FIFO: count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; count is (log2(FIFO_DEPTH)+1) bits.
- rst asserted mid-operation: pending events and the pending output are discarded immediately; a new sweep starts.

Decomposition:
- Shared package/header neuro_defs: default WEIGHT_W, ADDR_W, N_NEURONS constants, and the zero-weight constant.
- One sub-module, syn_event_fifo:
  - parametrised by width ADDR_W and depth FIFO_DEPTH;
  - ports push/pop/full/empty/head;
  - asynchronous reset.
- FSM, memory array and output register stay in syn_weight_mem.

Test Plan:
- Post-reset sweep: release rst -> busy=1 for exactly 16 cycles, then 0. Event addr 5 -> weight_out=0, valid.
- Write/read: write addr 3=10, addr 7=-5 (11'h7FB). Events 3,7,2 with weight_ready=1 -> weight_out 10, 2043(0x7FB), 0 on consecutive cycles, each valid one cycle after acceptance.
- Write-priority collision: we=1 addr 3=100 on the same cycle event 3 is at the FIFO head -> lookup stalls one cycle; weight_out=100.
- Backpressure/full: weight_ready=0, push 6 events -> 1 in the output register plus 4 in the FIFO; aer_ready=0 after the 5th acceptance. Release weight_ready -> all 5 weights in order, no loss.
- Clear mid-traffic: weights programmed, pulse clear, push events 3,4 during busy -> aer_ready stays 1, no weight_valid while busy; after the sweep both return 0. A we during busy is not applied.
- Out-of-range/reset: N_NEURONS=12, write addr 14 ignored; event addr 14 -> weight_out=0. Assert rst with 3 queued events -> weight_valid=0 at once, FIFO empty, busy=1.

Source files
------------

// File: rtl/syn_weight_mem_pkg.sv
// Shared constants and types for the synaptic weight memory block.
package syn_weight_mem_pkg;

  localparam int unsigned DefNNeurons  = 16;
  localparam int unsigned DefAddrW     = 4;
  localparam int unsigned DefWeightW   = 11;
  localparam int unsigned DefFifoDepth = 4;

  localparam logic [DefWeightW-1:0] ZeroWeight = '0;

  typedef enum logic {
    StIdle,
    StClear
  } state_e;

endpackage

// File: rtl/syn_event_fifo.sv
// Small power-of-two event FIFO; full/empty derived from an occupancy counter.
module syn_event_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/syn_weight_mem.sv
// Per-neuron synaptic weight RAM: queued AER lookups, host write port, sequential clear sweep.
module syn_weight_mem
  import syn_weight_mem_pkg::*;
#(
  parameter int unsigned N_NEURONS  = DefNNeurons,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned WEIGHT_W   = DefWeightW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   syn_addr,
  input  logic [WEIGHT_W-1:0] syn_weight,
  input  logic                clear,
  output logic                busy,
  input  logic                aer_valid,
  input  logic [ADDR_W-1:0]   aer_addr,
  output logic                aer_ready,
  output logic                weight_valid,
  output logic [WEIGHT_W-1:0] weight_out,
  input  logic                weight_ready
);

  localparam int unsigned       ClrW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [ClrW-1:0]   LastIdx   = ClrW'(N_NEURONS - 1);
  localparam logic [ADDR_W:0]   AddrLimit = (ADDR_W + 1)'(N_NEURONS);
  localparam logic [WEIGHT_W-1:0] Zero    = WEIGHT_W'(ZeroWeight);

  state_e              state_q, state_d;
  logic [ClrW-1:0]     cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [WEIGHT_W-1:0] out_q, out_d;
  logic [WEIGHT_W-1:0] mem_q [N_NEURONS];

  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] fifo_head;
  logic              idle, wr_en, push, lookup;

  syn_event_fifo #(
    .Width (ADDR_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (lookup),
    .din_i   (aer_addr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign busy         = busy_q;
  assign weight_valid = valid_q;
  assign weight_out   = out_q;
  assign aer_ready    = ~fifo_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ClrW'(1);
        end
      end
      default: state_d = StClear;
    endcase
    busy_d = (state_d == StClear);
  end

  // Host writes win over lookups so a same-cycle write is seen by the stalled read.
  always_comb begin
    idle    = (state_q == StIdle);
    wr_en   = we & idle & ({1'b0, syn_addr} < AddrLimit);
    push    = aer_valid & ~fifo_full;
    lookup  = ~fifo_empty & idle & ~we & (~valid_q | weight_ready);
    valid_d = valid_q;
    out_d   = out_q;
    if (lookup) begin
      valid_d = 1'b1;
      out_d   = ({1'b0, fifo_head} < AddrLimit) ? mem_q[fifo_head] : Zero;
    end else if (weight_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= Zero;
    end else if (wr_en) begin
      mem_q[syn_addr] <= syn_weight;
    end
  end

endmodule

// File: tb/tb_syn_weight_mem.sv
// Bench for syn_weight_mem: queue-based reference model plus directed literal checks.
module tb_syn_weight_mem;

  localparam int NN = 16;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  syn_addr = '0;
  logic [10:0] syn_weight = '0;
  logic        clear = 1'b0;
  logic        aer_valid = 1'b0;
  logic [3:0]  aer_addr = '0;
  logic        weight_ready = 1'b1;
  logic        busy, aer_ready, weight_valid;
  logic [10:0] weight_out;

  logic        rst12 = 1'b1;
  logic        we12 = 1'b0;
  logic [3:0]  addr12 = '0;
  logic [10:0] w12 = '0;
  logic        clr12 = 1'b0;
  logic        aerv12 = 1'b0;
  logic [3:0]  aera12 = '0;
  logic        busy12, aer_rdy12, wv12;
  logic [10:0] wo12;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  syn_weight_mem u_dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .syn_addr     (syn_addr),
    .syn_weight   (syn_weight),
    .clear        (clear),
    .busy         (busy),
    .aer_valid    (aer_valid),
    .aer_addr     (aer_addr),
    .aer_ready    (aer_ready),
    .weight_valid (weight_valid),
    .weight_out   (weight_out),
    .weight_ready (weight_ready)
  );

  syn_weight_mem #(
    .N_NEURONS (12)
  ) u_dut12 (
    .clk          (clk),
    .rst          (rst12),
    .we           (we12),
    .syn_addr     (addr12),
    .syn_weight   (w12),
    .clear        (clr12),
    .busy         (busy12),
    .aer_valid    (aerv12),
    .aer_addr     (aera12),
    .aer_ready    (aer_rdy12),
    .weight_valid (wv12),
    .weight_out   (wo12),
    .weight_ready (1'b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending events as a queue, output slot, remaining sweep cycles.
  int          m_q[$];
  bit          m_ov = 1'b0;
  logic [10:0] m_ow = '0;
  int          m_busy = NN;
  logic [10:0] m_mem[NN];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ov   = 1'b0;
      m_ow   = '0;
      m_busy = NN;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      automatic bit is_idle = (m_busy == 0);
      automatic bit do_push = aer_valid && (m_q.size() < FD);
      automatic bit do_pop  = (m_q.size() > 0) && is_idle && !we && (!m_ov || weight_ready);
      if (do_pop) begin
        automatic int a = m_q.pop_front();
        m_ov = 1'b1;
        m_ow = (a < NN) ? m_mem[a] : 11'd0;
      end else if (weight_ready) begin
        m_ov = 1'b0;
      end
      if (do_push) m_q.push_back(int'(aer_addr));
      if (is_idle && we && int'(syn_addr) < NN) m_mem[int'(syn_addr)] = syn_weight;
      if (!is_idle) begin
        m_busy--;
      end else if (clear) begin
        m_busy = NN;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 32'(busy), 32'(m_busy != 0));
      check("model_aer_ready", 32'(aer_ready), 32'(m_q.size() < FD));
      check("model_valid", 32'(weight_valid), 32'(m_ov));
      check("model_out", 32'(weight_out), 32'(m_ow));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [10:0] w);
    we = 1'b1;
    syn_addr = a;
    syn_weight = w;
    tick();
    we = 1'b0;
  endtask

  task automatic send(input logic [3:0] a);
    aer_valid = 1'b1;
    aer_addr = a;
    tick();
    aer_valid = 1'b0;
  endtask

  logic [10:0] bp_w[5] = '{11'h7F3, 11'h7FA, 11'h001, 11'h008, 11'h00F};

  initial begin
    int n;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 1);
    check("rst_valid", 32'(weight_valid), 0);
    check("rst_out", 32'(weight_out), 0);
    check("rst_aer_ready", 32'(aer_ready), 1);
    rst = 1'b0;
    rst12 = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("sweep_len", n, 16);

    send(4'd5);
    check("lat_not_early", 32'(weight_valid), 0);
    tick();
    check("sweep_ev5_valid", 32'(weight_valid), 1);
    check("sweep_ev5_out", 32'(weight_out), 0);

    wr(4'd3, 11'd10);
    wr(4'd7, 11'h7FB);
    aer_valid = 1'b1;
    aer_addr = 4'd3;
    tick();
    aer_addr = 4'd7;
    tick();
    check("rd3", 32'(weight_out), 10);
    check("rd3_valid", 32'(weight_valid), 1);
    aer_addr = 4'd2;
    tick();
    aer_valid = 1'b0;
    check("rd7", 32'(weight_out), 2043);
    tick();
    check("rd2", 32'(weight_out), 0);
    check("rd2_valid", 32'(weight_valid), 1);
    tick();
    check("rd_drain", 32'(weight_valid), 0);

    send(4'd3);
    wr(4'd3, 11'd100);
    check("coll_stall", 32'(weight_valid), 0);
    tick();
    check("coll_valid", 32'(weight_valid), 1);
    check("coll_out", 32'(weight_out), 100);

    for (int i = 0; i < 5; i++) wr(4'(i + 1), bp_w[i]);
    weight_ready = 1'b0;
    aer_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      aer_addr = 4'(i + 1);
      tick();
    end
    check("full_ready", 32'(aer_ready), 0);
    aer_addr = 4'd6;
    tick();
    check("full_hold_ready", 32'(aer_ready), 0);
    check("full_hold_out", 32'(weight_out), 32'(11'h7F3));
    aer_valid = 1'b0;
    weight_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check("bp_order", 32'(weight_out), 32'(bp_w[i]));
      check("bp_valid", 32'(weight_valid), 1);
    end
    tick();
    check("bp_drained", 32'(weight_valid), 0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", 32'(busy), 1);
    aer_valid = 1'b1;
    aer_addr = 4'd3;
    tick();
    check("clr_aer_ready", 32'(aer_ready), 1);
    aer_addr = 4'd4;
    tick();
    aer_valid = 1'b0;
    check("clr_aer_ready2", 32'(aer_ready), 1);
    wr(4'd0, 11'd55);
    n = 3;
    while (busy && n < 100) begin
      check("clr_no_valid", 32'(weight_valid), 0);
      tick();
      n++;
    end
    check("clr_len", n, 16);
    tick();
    check("clr_w3_valid", 32'(weight_valid), 1);
    check("clr_w3", 32'(weight_out), 0);
    tick();
    check("clr_w4_valid", 32'(weight_valid), 1);
    check("clr_w4", 32'(weight_out), 0);
    send(4'd0);
    tick();
    check("we_dropped_valid", 32'(weight_valid), 1);
    check("we_dropped", 32'(weight_out), 0);

    wr(4'd2, 11'd9);
    weight_ready = 1'b0;
    aer_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      aer_addr = 4'(i);
      tick();
    end
    aer_valid = 1'b0;
    check("pre_rst_valid", 32'(weight_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(weight_valid), 0);
    check("mid_rst_out", 32'(weight_out), 0);
    check("mid_rst_busy", 32'(busy), 1);
    check("mid_rst_ready", 32'(aer_ready), 1);
    tick();
    rst = 1'b0;
    weight_ready = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("rst_sweep_len", n, 16);
    tick();
    tick();
    check("post_rst_empty", 32'(weight_valid), 0);

    check("n12_idle", 32'(busy12), 0);
    clr12 = 1'b1;
    tick();
    clr12 = 1'b0;
    n = 0;
    while (busy12 && n < 100) begin
      tick();
      n++;
    end
    check("n12_sweep_len", n, 12);
    we12 = 1'b1;
    addr12 = 4'd14;
    w12 = 11'd77;
    tick();
    addr12 = 4'd11;
    w12 = 11'h7FF;
    tick();
    we12 = 1'b0;
    aerv12 = 1'b1;
    aera12 = 4'd14;
    tick();
    aera12 = 4'd11;
    tick();
    aerv12 = 1'b0;
    check("n12_oor_valid", 32'(wv12), 1);
    check("n12_oor_out", 32'(wo12), 0);
    tick();
    check("n12_last_out", 32'(wo12), 2047);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
